// File: rtl/pwm_ramp_ctrl_pkg.sv
// rtl/pwm_ramp_ctrl_pkg.sv - shared state encoding and width helper for the duty ramp sequencer
package pwm_ramp_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// rtl/pwm_slew_step.sv - one slew step: move cur toward tgt by at most STEP, saturating at tgt
module pwm_slew_step #(
  parameter int DW        = 16,
  parameter int STEP      = 256,
  parameter int CLK_TICKS = 65536
) (
  input  logic [DW-1:0] cur_i,
  input  logic [DW-1:0] tgt_i,
  output logic [DW-1:0] nxt_o
);

  localparam bit            JUMP   = (STEP == 0) || (STEP >= CLK_TICKS);
  localparam logic [DW-1:0] STEP_D = DW'(STEP);

  logic [DW:0] cur_x;
  logic [DW:0] tgt_x;

  assign cur_x = {1'b0, cur_i};
  assign tgt_x = {1'b0, tgt_i};

  // Distance is compared against STEP before adding/subtracting, so the result never wraps.
  always_comb begin
    nxt_o = cur_i;
    if (JUMP) begin
      nxt_o = tgt_i;
    end else if (cur_x < tgt_x) begin
      nxt_o = ((tgt_x - cur_x) > {1'b0, STEP_D}) ? (cur_i + STEP_D) : tgt_i;
    end else if (cur_x > tgt_x) begin
      nxt_o = ((cur_x - tgt_x) > {1'b0, STEP_D}) ? (cur_i - STEP_D) : tgt_i;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - multi-channel duty sequencer slewing live duty toward target once per period
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int  CLK_TICKS = 65536,
  parameter int  NCH       = 4,
  parameter int  STEP      = 256,
  localparam int DW        = $clog2(CLK_TICKS),
  localparam int CW        = ch_width(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_tick,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_ch,
  input  logic [DW-1:0]     wr_duty,
  input  logic              wr_imm,
  output logic [NCH*DW-1:0] duty_out,
  output logic [NCH-1:0]    settled,
  output logic              busy,
  output logic              overrun
);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] tgt_q [NCH];
  logic [DW-1:0] tgt_d [NCH];
  logic [DW-1:0] cur_q [NCH];
  logic [DW-1:0] cur_d [NCH];
  logic [DW-1:0] sel_cur, sel_tgt, slew_nxt;
  logic          last_idx, wr_fire;

  assign last_idx = (idx_q == CW'(NCH - 1));
  assign wr_fire  = wr_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (state_q == ST_IDLE) begin
      if (period_tick) begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end
    end else begin
      // A tick during a scan is not queued; it is only flagged.
      if (period_tick) overrun_d = 1'b1;
      if (last_idx) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_cur = '0;
    sel_tgt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == CW'(k)) begin
        sel_cur = cur_q[k];
        sel_tgt = tgt_q[k];
      end
    end
  end

  pwm_slew_step #(
    .DW        (DW),
    .STEP      (STEP),
    .CLK_TICKS (CLK_TICKS)
  ) u_slew (
    .cur_i (sel_cur),
    .tgt_i (sel_tgt),
    .nxt_o (slew_nxt)
  );

  // Writes only land in IDLE and the slew only in SCAN, so the two never collide on a channel.
  // Out-of-range channel indices match no k and are silently dropped.
  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    for (int k = 0; k < NCH; k++) begin
      if ((state_q == ST_SCAN) && (idx_q == CW'(k))) cur_d[k] = slew_nxt;
      if (wr_fire && (wr_ch == CW'(k))) begin
        tgt_d[k] = wr_duty;
        if (wr_imm) cur_d[k] = wr_duty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        tgt_q[k] <= '0;
        cur_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
    end
  end

  assign wr_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_SCAN);
  assign overrun  = overrun_q;

  always_comb begin
    duty_out = '0;
    settled  = '0;
    for (int k = 0; k < NCH; k++) begin
      duty_out[k*DW +: DW] = cur_q[k];
      settled[k]           = (cur_q[k] == tgt_q[k]);
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        period_tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ch;
  logic [15:0] wr_duty;
  logic        wr_imm;
  logic [63:0] duty_out;
  logic [3:0]  settled;
  logic        busy;
  logic        overrun;

  logic        period_tick3;
  logic        wr_valid3;
  logic        wr_ready3;
  logic [1:0]  wr_ch3;
  logic [15:0] wr_duty3;
  logic        wr_imm3;
  logic [47:0] duty_out3;
  logic [2:0]  settled3;
  logic        busy3;
  logic        overrun3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .wr_imm      (wr_imm),
    .duty_out    (duty_out),
    .settled     (settled),
    .busy        (busy),
    .overrun     (overrun)
  );

  pwm_ramp_ctrl #(.NCH(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick3),
    .wr_valid    (wr_valid3),
    .wr_ready    (wr_ready3),
    .wr_ch       (wr_ch3),
    .wr_duty     (wr_duty3),
    .wr_imm      (wr_imm3),
    .duty_out    (duty_out3),
    .settled     (settled3),
    .busy        (busy3),
    .overrun     (overrun3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dch(input int k);
    return duty_out[k*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] duty, input logic imm);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_duty  = duty;
    wr_imm   = imm;
    step();
    wr_valid = 1'b0;
    wr_imm   = 1'b0;
  endtask

  task automatic period();
    period_tick = 1'b1;
    step();
    period_tick = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b0; period_tick = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0; wr_imm = 1'b0;
    period_tick3 = 1'b0; wr_valid3 = 1'b0; wr_ch3 = '0; wr_duty3 = '0; wr_imm3 = 1'b0;
    repeat (2) step();
    chk("rst_duty", duty_out, 64'd0);
    chk("rst_settled", settled, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    rst = 1'b1;
    step();

    // Ramp up ch1 to 1000
    wr(2'd1, 16'd1000, 1'b0);
    chk("up_settled_pre", settled, 4'hD);
    period_tick = 1'b1;
    step();
    period_tick = 1'b0;
    chk("scan_busy", busy, 1'b1);
    repeat (4) step();
    chk("scan_done", busy, 1'b0);
    chk("up_t1", dch(1), 16'd256);
    period(); chk("up_t2", dch(1), 16'd512);
    period(); chk("up_t3", dch(1), 16'd768);
    period(); chk("up_t4", dch(1), 16'd1000);
    chk("up_settled", settled, 4'hF);
    chk("up_others", duty_out, {16'd0, 16'd0, 16'd1000, 16'd0});

    // Immediate load then ramp down
    wr(2'd2, 16'd600, 1'b1);
    chk("imm_load", dch(2), 16'd600);
    wr(2'd2, 16'd100, 1'b0);
    period(); chk("down_t1", dch(2), 16'd344);
    period(); chk("down_t2", dch(2), 16'd100);
    chk("down_settled", settled, 4'hF);

    // Top of range, no wrap
    wr(2'd3, 16'd65400, 1'b1);
    wr(2'd3, 16'd65535, 1'b0);
    period(); chk("max_no_wrap", dch(3), 16'd65535);

    // Collision: tick while busy, write while busy
    period_tick = 1'b1;
    step();
    chk("col_busy0", busy, 1'b1);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_duty = 16'd512; wr_imm = 1'b0;
    chk("col_ready0", wr_ready, 1'b0);
    step();
    period_tick = 1'b0;
    chk("col_overrun", overrun, 1'b1);
    chk("col_ready1", wr_ready, 1'b0);
    step();
    step();
    chk("col_busy3", busy, 1'b1);
    step();
    chk("col_len", busy, 1'b0);
    chk("col_ready_idle", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    chk("col_accept", settled, 4'hE);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_duty = 16'd200; period_tick = 1'b1;
    step();
    wr_valid = 1'b0; period_tick = 1'b0;
    repeat (4) step();
    chk("col_new_tgt", dch(0), 16'd200);
    chk("col_overrun_sticky", overrun, 1'b1);

    // Reset mid-scan
    wr(2'd1, 16'd5000, 1'b0);
    period_tick = 1'b1;
    step();
    period_tick = 1'b0;
    step();
    step();
    chk("mid_ch1", dch(1), 16'd1256);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b0;
    step();
    chk("mrst_duty", duty_out, 64'd0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_settled", settled, 4'hF);
    chk("mrst_overrun", overrun, 1'b0);
    chk("mrst_ready", wr_ready, 1'b1);
    rst = 1'b1;
    step();

    // Out-of-range channel on a 3-channel instance
    wr_valid3 = 1'b1; wr_ch3 = 2'd3; wr_duty3 = 16'd777; wr_imm3 = 1'b1;
    chk("drop_ready", wr_ready3, 1'b1);
    step();
    chk("drop_duty", duty_out3, 48'd0);
    chk("drop_settled", settled3, 3'b111);
    wr_ch3 = 2'd2;
    step();
    wr_valid3 = 1'b0; wr_imm3 = 1'b0;
    chk("n3_ch2", duty_out3[47:32], 16'd777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
